// File: rtl/cyphertext_byte_streamer_pkg.sv
// Shared constants and FSM encoding for the cyphertext byte streamer.
// Mirrors the block width and stream defaults of the AES core.
package cyphertext_byte_streamer_pkg;

  localparam int CBS_TEXT_WIDTH = 128;
  localparam int CBS_FIFO_DEPTH = 4;
  localparam int CBS_CNT_WIDTH  = 16;
  localparam int CBS_BYTE_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } cbs_state_e;

endpackage

// File: rtl/cyphertext_byte_streamer_block_fifo.sv
// Register FIFO of whole cyphertext blocks.
// A push into a full FIFO is still taken when a pop frees a slot.
module block_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       drop_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cyphertext_byte_streamer.sv
// Captures finished AES blocks and streams them out MSB byte first
// over a valid/ready byte port, flagging blocks lost to a full FIFO.
module cyphertext_byte_streamer
  import cyphertext_byte_streamer_pkg::*;
#(
  parameter int TEXT_WIDTH = CBS_TEXT_WIDTH,
  parameter int FIFO_DEPTH = CBS_FIFO_DEPTH,
  parameter int CNT_WIDTH  = CBS_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  finish_i,
  input  logic [TEXT_WIDTH-1:0] cyphertext_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  overflow_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  blocks_sent_o
);

  localparam int NBYTES = TEXT_WIDTH / CBS_BYTE_W;
  localparam int IW     = $clog2(NBYTES);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  cbs_state_e            state_q, state_d;
  logic                  finish_d_q;
  logic [TEXT_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            byte_q, byte_d;
  logic                  bvalid_q, bvalid_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  logic                  ovf_q, ovf_d;

  logic                  push, pop, drop;
  logic [TEXT_WIDTH-1:0] head;
  logic [CW-1:0]         count;

  assign push = finish_i & ~finish_d_q;
  assign pop  = (state_q == ST_IDLE) & ~fifo_empty_o;

  block_fifo #(
    .WIDTH (TEXT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cyphertext_i),
    .data_o  (head),
    .drop_o  (drop),
    .count_o (count)
  );

  assign fifo_full_o   = (count == CW'(FIFO_DEPTH));
  assign fifo_empty_o  = (count == '0);
  assign byte_o        = byte_q;
  assign byte_valid_o  = bvalid_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign blocks_sent_o = sent_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    bvalid_d = bvalid_q;
    sent_d   = sent_q;
    ovf_d    = ovf_q | drop;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_o) begin
          shift_d = head;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bvalid_d = 1'b1;
        byte_d   = shift_q[TEXT_WIDTH-1 -: 8];
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (byte_ready_i) begin
          if (idx_q == IW'(NBYTES - 1)) begin
            sent_d   = sent_q + 1'b1;
            bvalid_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            shift_d = shift_q << 8;
            byte_d  = shift_q[TEXT_WIDTH-9 -: 8];
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      finish_d_q <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      bvalid_q   <= 1'b0;
      sent_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      finish_d_q <= finish_i;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      bvalid_q   <= bvalid_d;
      sent_q     <= sent_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cyphertext_byte_streamer.sv
// Scoreboard bench: expected bytes queued at stimulus, popped by a monitor.
module tb_cyphertext_byte_streamer;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         finish_i = 1'b0;
  logic [127:0] cyphertext_i = '0;
  logic         byte_ready_i = 1'b0;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         fifo_full_o;
  logic         fifo_empty_o;
  logic         overflow_o;
  logic         busy_o;
  logic [15:0]  blocks_sent_o;

  cyphertext_byte_streamer dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .finish_i      (finish_i),
    .cyphertext_i  (cyphertext_i),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .byte_ready_i  (byte_ready_i),
    .fifo_full_o   (fifo_full_o),
    .fifo_empty_o  (fifo_empty_o),
    .overflow_o    (overflow_o),
    .busy_o        (busy_o),
    .blocks_sent_o (blocks_sent_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int blocks_done = 0;
  int in_blk = 0;
  int rx_total = 0;
  int pushed = 0;
  logic hold_pend = 1'b0;
  logic [7:0] hold_byte = '0;
  int rdy_mode = 0;
  logic rdy_val = 1'b0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       byte_ready_i = rdy_val;
      1:       byte_ready_i = 1'($urandom_range(0, 1));
      default: byte_ready_i = (cyc % 3 == 0);
    endcase
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 128'(byte_valid_o), 128'(1));
        chk("hold_byte", 128'(byte_o), 128'(hold_byte));
      end
      hold_pend = 1'b0;
      if (byte_valid_o) begin
        if (byte_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 128'(byte_valid_o), 128'(0));
          end else begin
            chk("byte", 128'(byte_o), 128'(exp_q.pop_front()));
            rx_total++;
            in_blk++;
            if (in_blk == 16) begin
              in_blk = 0;
              blocks_done++;
            end
          end
        end else begin
          hold_pend = 1'b1;
          hold_byte = byte_o;
        end
      end
    end
  end

  task automatic push_blk(input logic [127:0] d);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(d[127-8*k -: 8]);
    end
    pushed++;
  endtask

  task automatic pulse(input logic [127:0] d);
    @(posedge clk);
    #1;
    cyphertext_i = d;
    finish_i = 1'b1;
    @(posedge clk);
    #1;
    finish_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    finish_i = 1'b0;
    #1;
    chk("rst_byte", 128'(byte_o), 128'(0));
    chk("rst_valid", 128'(byte_valid_o), 128'(0));
    chk("rst_ovf", 128'(overflow_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_sent", 128'(blocks_sent_o), 128'(0));
    chk("rst_full", 128'(fifo_full_o), 128'(0));
    chk("rst_empty", 128'(fifo_empty_o), 128'(1));
    exp_q.delete();
    blocks_done = 0;
    in_blk = 0;
    pushed = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 128'(exp_q.size()), 128'(0));
    chk("drain_busy", 128'(busy_o), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] KAT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int n;
    int rx0;
    logic [127:0] d;

    // single block, ready high
    rdy_mode = 0;
    rdy_val = 1'b1;
    do_reset();
    push_blk(KAT);
    pulse(KAT);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n = i;
      if (byte_valid_o) break;
    end
    chk("latency", 128'(n), 128'(3));
    n = 0;
    while (byte_valid_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("consecutive", 128'(n), 128'(16));
    wait_drain(100);
    chk("t1_sent", 128'(blocks_sent_o), 128'(1));
    chk("t1_empty", 128'(fifo_empty_o), 128'(1));

    // backpressure pattern
    do_reset();
    rdy_mode = 2;
    rx0 = rx_total;
    push_blk(KAT);
    pulse(KAT);
    wait_drain(200);
    chk("t2_xfers", 128'(rx_total - rx0), 128'(16));
    chk("t2_sent", 128'(blocks_sent_o), 128'(1));

    // long finish level
    do_reset();
    rdy_mode = 0;
    rdy_val = 1'b1;
    d = 128'h00112233445566778899aabbccddeeff;
    push_blk(d);
    @(posedge clk);
    #1;
    cyphertext_i = d;
    finish_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    finish_i = 1'b0;
    wait_drain(100);
    repeat (30) @(negedge clk);
    chk("t3_sent", 128'(blocks_sent_o), 128'(1));

    // fill and overflow
    rdy_val = 1'b0;
    do_reset();
    repeat (2) @(posedge clk);
    for (int b = 1; b <= 5; b++) begin
      d = {16{8'(b)}};
      push_blk(d);
      pulse(d);
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    chk("t4_full", 128'(fifo_full_o), 128'(1));
    chk("t4_ovf0", 128'(overflow_o), 128'(0));
    pulse({16{8'h06}});
    @(negedge clk);
    chk("t4_ovf1", 128'(overflow_o), 128'(1));
    rdy_val = 1'b1;
    wait_drain(400);
    chk("t4_sent", 128'(blocks_sent_o), 128'(5));
    chk("t4_ovf_sticky", 128'(overflow_o), 128'(1));

    // reset mid-stream
    do_reset();
    push_blk(KAT);
    pulse(KAT);
    n = 0;
    while (in_blk < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach", 128'(in_blk), 128'(5));
    do_reset();
    repeat (40) @(negedge clk);
    chk("t5_sent", 128'(blocks_sent_o), 128'(0));
    chk("t5_valid", 128'(byte_valid_o), 128'(0));
    chk("t5_empty", 128'(fifo_empty_o), 128'(1));

    // full with simultaneous push and pop
    rdy_val = 1'b0;
    do_reset();
    repeat (2) @(posedge clk);
    for (int b = 0; b < 5; b++) begin
      d = {16{8'(8'ha0 + b)}};
      push_blk(d);
      pulse(d);
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    chk("t6_full", 128'(fifo_full_o), 128'(1));
    rdy_val = 1'b1;
    n = 0;
    while (!(!busy_o && fifo_full_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_idle_full", 128'(busy_o), 128'(0));
    d = {16{8'haf}};
    push_blk(d);
    cyphertext_i = d;
    finish_i = 1'b1;
    @(posedge clk);
    #1;
    finish_i = 1'b0;
    @(negedge clk);
    chk("t6_still_full", 128'(fifo_full_o), 128'(1));
    chk("t6_ovf", 128'(overflow_o), 128'(0));
    wait_drain(400);
    chk("t6_sent", 128'(blocks_sent_o), 128'(6));

    // randomized blocks and ready
    do_reset();
    rdy_mode = 1;
    for (int b = 0; b < 12; b++) begin
      n = 0;
      while ((pushed - blocks_done) >= 4 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("rnd_wait", 128'(n < 2000), 128'(1));
      repeat ($urandom_range(0, 15)) @(posedge clk);
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_blk(d);
      pulse(d);
    end
    wait_drain(3000);
    chk("rnd_sent", 128'(blocks_sent_o), 128'(12));
    chk("rnd_model", 128'(blocks_sent_o), 128'(blocks_done));
    chk("rnd_ovf", 128'(overflow_o), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cyphertext_byte_streamer.md
Name: cyphertext_byte_streamer

Overview:
- Sits downstream of the AES encryption core. It runs alongside the cyphertext RAM and receives the same finish_o / addroundkey_reg_o pair.
- Captures each finished 128-bit cyphertext block into a small FIFO.
- Serialises each block into bytes, MSB byte first, over a valid/ready byte interface. A UART or host reader drains that interface.
- Decouples AES throughput from a slow byte consumer and flags any lost blocks.

Parameters:
- TEXT_WIDTH, 128, block width. Taken from the shared `TEXT_WIDTH define.
- FIFO_DEPTH, 4, number of buffered blocks. Must be a power of two and at least 2.
- CNT_WIDTH, 16, width of the sent-block counter.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- finish_i  input  1  AES finish flag (level). A 0->1 transition marks a valid block.
- cyphertext_i  input  TEXT_WIDTH  cyphertext from the AES round register. Sampled on the cycle the finish_i rise is detected.
- byte_o  output  8  current output byte.
- byte_valid_o  output  1  byte_o holds a valid byte.
- byte_ready_i  input  1  consumer accepts byte_o this cycle.
- fifo_full_o  output  1  all FIFO_DEPTH entries occupied.
- fifo_empty_o  output  1  no buffered blocks.
- overflow_o  output  1  sticky: at least one block was dropped.
- busy_o  output  1  streamer FSM not in IDLE.
- blocks_sent_o  output  CNT_WIDTH  count of fully transmitted blocks.

Behaviour:
- Reset (async, rst_ni=0), all cleared:
  - byte_o=0, byte_valid_o=0, overflow_o=0, busy_o=0, blocks_sent_o=0, fifo_full_o=0, fifo_empty_o=1.
  - FIFO pointers and count=0, finish edge register=0, FSM=IDLE.
- Capture:
  - finish_d register holds finish_i from the previous cycle. push = finish_i & ~finish_d.
  - A long finish_i level therefore captures exactly once.
  - On push with FIFO not full, cyphertext_i is written at wr_ptr, and wr_ptr and count advance.
- Overflow:
  - push while full and no pop in the same cycle: the block is dropped and overflow_o sets to 1. It stays 1 until reset.
  - push and pop in the same cycle while full: the push is accepted and count is unchanged.
- Pointers:
  - log2(FIFO_DEPTH) bits, wrap modulo depth.
  - fifo_full_o = (count==FIFO_DEPTH); fifo_empty_o = (count==0). Both are combinational from registered count.
- FSM states: IDLE, LOAD, SEND.
  - IDLE: if FIFO not empty, pop the head into a 128-bit shift register, set byte index=0, go to LOAD. Otherwise stay.
  - LOAD: byte_valid_o=1, byte_o=shift_reg[127:120]; go to SEND.
  - SEND, byte_valid_o=1:
    - On byte_ready_i=1 with index<15: shift left 8, index+1, stay in SEND.
    - On byte_ready_i=1 with index==15: blocks_sent_o increments (wraps at 2^CNT_WIDTH), byte_valid_o=0, go to IDLE.
    - byte_ready_i=0: hold byte_o and byte_valid_o stable.
  - byte_valid_o, once high, never drops before acceptance.
- Latency: finish_i rise sampled at edge N. Entry written at edge N, popped at N+1, byte_valid_o high after N+2. The first byte is visible 2 cycles after capture.
- Throughput:
  - With ready tied high, one block takes 16 byte cycles plus 2 overhead cycles (IDLE pop, LOAD).
  - back-to-back blocks: 18 cycles per block.
- busy_o = (state != IDLE).
- Reset mid-block: the partial block is discarded, no byte is emitted after reset deasserts until a new capture, and the counter restarts at 0.
- Byte order: byte k = cyphertext_i[127-8k : 120-8k]. This matches the %h text dump order used for cyphertext_ascii.txt.

Decomposition:
- Shared def.v keeps `TEXT_WIDTH.
- Add `STREAM_FIFO_DEPTH (4) and FSM state encodings `ST_IDLE=2'd0, `ST_LOAD=2'd1, `ST_SEND=2'd2 to def.v.
- One sub-module: block_fifo. It holds the parameterised 128-bit register FIFO with push/pop/full/empty/count.
- The top module holds the edge detect, FSM, shift register and counter.

Test Plan:
1. Single block: finish_i rises with cyphertext_i=128'h69c4e0d86a7b0430d8cdb78070b4c55a, byte_ready_i=1.
   -> byte_valid_o rises 2 cycles later. Bytes 69,c4,e0,...,c5,5a on 16 consecutive cycles. Then blocks_sent_o=1 and fifo_empty_o=1.
2. Backpressure: same block with byte_ready_i toggling 1,0,0,1,...
   -> byte_o holds each value while ready=0. Exactly 16 transfers occur, in the same order, with no duplicates.
3. Level finish: finish_i held high 10 cycles.
   -> exactly one capture, and blocks_sent_o ends at 1.
4. Fill/overflow: byte_ready_i=0, then 6 finish pulses with blocks 0x01..01 to 0x06..06.
   -> blocks 1 sits in the shift register. Blocks 2-5 fill the FIFO and fifo_full_o=1. Block 6 is dropped and overflow_o=1.
   -> Release ready: bytes of blocks 1-5 stream in order, blocks_sent_o=5, overflow_o stays 1.
5. Reset mid-stream: assert rst_ni=0 after byte 5 of a block.
   -> all outputs return to reset values immediately (async). Nothing is emitted after release, blocks_sent_o=0.
6. Full with simultaneous push/pop: FIFO full and IDLE pops on the same cycle a finish rise arrives.
   -> the push is accepted, overflow_o=0, count stays 4.
